atm_cash_dispense_ctrl: RTL and testbench

Controller for the ATM note dispenser. It is called by the ATM main FSM during the give-money step. It turns a requested amount into a count of notes and feeds the notes one at a time with a feed/sense handshake. It then presents the cash at the shutter and retracts it if the customer does not take it, while tracking note inventory and jam status.

---
 rtl/atm_pkg.sv | 32 +++
 rtl/atm_cash_dispense_ctrl_if.sv | 38 +++
 rtl/atm_timeout_timer.sv | 29 ++
 rtl/atm_cash_dispense_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_atm_cash_dispense_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared types and default constants for the ATM cash dispense controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package atm_pkg;

  // Controller states; encodings are visible on the debug state port.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CALC      = 4'd1,
    ST_CHECK     = 4'd2,
    ST_FEED      = 4'd3,
    ST_WAIT_NOTE = 4'd4,
    ST_PRESENT   = 4'd5,
    ST_RETRACT   = 4'd6,
    ST_DONE      = 4'd7
  } stateT;

  // Completion status reported alongside the done pulse.
  typedef enum logic [2:0] {
    STAT_OK         = 3'd0,
    STAT_BAD_AMOUNT = 3'd1,
    STAT_NO_CASH    = 3'd2,
    STAT_JAM        = 3'd3,
    STAT_RETRACTED  = 3'd4
  } statusT;

  localparam int DEF_NOTE_VALUE      = 20;
  localparam int DEF_MAX_NOTES       = 40;
  localparam int DEF_FEED_TIMEOUT    = 8;
  localparam int DEF_PRESENT_TIMEOUT = 64;

endpackage

// File: rtl/atm_cash_dispense_ctrl_if.sv
// Bundle of request, mechanism and status signals of the cash dispenser.
// Latency: n/a (wiring only).
// Backpressure: none; the controller ignores requests while busy.
interface atm_cash_dispense_ctrl_if #(
  parameter int AMT_W = 16,
  parameter int INV_W = 12
);
  logic             dispense_req;
  logic [AMT_W-1:0] amount;
  logic             load_notes;
  logic [INV_W-1:0] load_count;
  logic             note_sensed;
  logic             money_taken;
  logic             note_feed;
  logic             shutter_open;
  logic             retract;
  logic             busy;
  logic             done;
  logic [2:0]       status;
  logic             jammed;
  logic [INV_W-1:0] inventory;
  logic [INV_W-1:0] notes_out;
  logic [3:0]       state;

  // Main FSM / mechanism side: drives requests and sensor inputs.
  modport master (
    output dispense_req, amount, load_notes, load_count, note_sensed, money_taken,
    input  note_feed, shutter_open, retract, busy, done, status, jammed,
           inventory, notes_out, state
  );

  // Dispense controller side.
  modport slave (
    input  dispense_req, amount, load_notes, load_count, note_sensed, money_taken,
    output note_feed, shutter_open, retract, busy, done, status, jammed,
           inventory, notes_out, state
  );
endinterface

// File: rtl/atm_timeout_timer.sv
// Loadable down-counter shared by the note-wait and shutter-present windows.
// Latency: expired rises in the Nth enabled cycle after loading N.
// Backpressure: none; load has priority over counting.
module atm_timeout_timer #(
  parameter int W = 7
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt;

  // Reload on request, otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // The last cycle of the window is the one where the count still reads 1.
  assign expired = en && (cnt == W'(1));
endmodule

// File: rtl/atm_cash_dispense_ctrl.sv
// ATM note dispenser: amount -> note count, per-note feed/sense, present/retract; option JAM_RETRY_EN.
// Latency: CALC up to MAX_NOTES+1 cycles, then 2 cycles/note minimum plus present window; done is 1 cycle.
// Backpressure: dispense_req/load_notes are only honoured in IDLE and ignored while busy.
module atm_cash_dispense_ctrl
  import atm_pkg::*;
#(
  parameter int NOTE_VALUE      = DEF_NOTE_VALUE,
  parameter int AMT_W           = 16,
  parameter int INV_W           = 12,
  parameter int MAX_NOTES       = DEF_MAX_NOTES,
  parameter int FEED_TIMEOUT    = DEF_FEED_TIMEOUT,
  parameter int PRESENT_TIMEOUT = DEF_PRESENT_TIMEOUT
)(
  input  logic                   clk,
  input  logic                   rst_n,
  atm_cash_dispense_ctrl_if.slave bus
);
  localparam int TMR_MAX = (FEED_TIMEOUT > PRESENT_TIMEOUT) ? FEED_TIMEOUT : PRESENT_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  stateT            curState, nextState;
  statusT           statusReg, statusNext;
  logic             statusWr;
  logic [AMT_W-1:0] remAmt;
  logic [INV_W-1:0] needCnt, invCnt, notesCnt;
  logic [INV_W:0]   invSum;
  logic             jamFlag;
  logic             loadAccept, acceptReq, calcStep, noteEvt, setJam;
  logic             timerLoad, timerEn, timerExpired;
  logic [TMR_W-1:0] timerLoadVal;
`ifdef JAM_RETRY_EN
  logic             retryFlag, retrySet;
`endif

  atm_timeout_timer #(.W(TMR_W)) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .en      (timerEn),
    .expired (timerExpired)
  );

  assign loadAccept = (curState == ST_IDLE) && bus.load_notes;
  assign invSum     = {1'b0, invCnt} + {1'b0, bus.load_count};
  assign timerEn    = (curState == ST_WAIT_NOTE) || (curState == ST_PRESENT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState <= ST_IDLE;
    end else begin
      curState <= nextState;
    end
  end

  // Next-state decode plus datapath strobes for the current state.
  always_comb begin
    nextState    = curState;
    statusNext   = statusReg;
    statusWr     = 1'b0;
    timerLoad    = 1'b0;
    timerLoadVal = TMR_W'(FEED_TIMEOUT);
    acceptReq    = 1'b0;
    calcStep     = 1'b0;
    noteEvt      = 1'b0;
    setJam       = 1'b0;
`ifdef JAM_RETRY_EN
    retrySet     = 1'b0;
`endif
    case (curState)
      ST_IDLE: begin
        if (bus.dispense_req) begin
          acceptReq = 1'b1;
          // A refill in the same cycle clears the jam before the request is judged.
          if (jamFlag && !bus.load_notes) begin
            nextState  = ST_DONE;
            statusNext = STAT_JAM;
            statusWr   = 1'b1;
          end else begin
            nextState = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (remAmt >= AMT_W'(NOTE_VALUE)) begin
          // Another note would exceed the per-transaction cap: abort early.
          if (needCnt >= INV_W'(MAX_NOTES)) begin
            nextState  = ST_DONE;
            statusNext = STAT_BAD_AMOUNT;
            statusWr   = 1'b1;
          end else begin
            calcStep = 1'b1;
          end
        end else if ((remAmt != '0) || (needCnt == '0)) begin
          nextState  = ST_DONE;
          statusNext = STAT_BAD_AMOUNT;
          statusWr   = 1'b1;
        end else begin
          nextState = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (needCnt > invCnt) begin
          nextState  = ST_DONE;
          statusNext = STAT_NO_CASH;
          statusWr   = 1'b1;
        end else begin
          nextState = ST_FEED;
        end
      end
      ST_FEED: begin
        timerLoad    = 1'b1;
        timerLoadVal = TMR_W'(FEED_TIMEOUT);
        nextState    = ST_WAIT_NOTE;
      end
      ST_WAIT_NOTE: begin
        // A sensed note beats a coincident timeout.
        if (bus.note_sensed) begin
          noteEvt = 1'b1;
          if ((notesCnt + INV_W'(1)) == needCnt) begin
            nextState    = ST_PRESENT;
            timerLoad    = 1'b1;
            timerLoadVal = TMR_W'(PRESENT_TIMEOUT);
          end else begin
            nextState = ST_FEED;
          end
        end else if (timerExpired) begin
`ifdef JAM_RETRY_EN
          if (!retryFlag) begin
            retrySet  = 1'b1;
            nextState = ST_FEED;
          end else begin
            setJam     = 1'b1;
            nextState  = ST_DONE;
            statusNext = STAT_JAM;
            statusWr   = 1'b1;
          end
`else
          setJam     = 1'b1;
          nextState  = ST_DONE;
          statusNext = STAT_JAM;
          statusWr   = 1'b1;
`endif
        end
      end
      ST_PRESENT: begin
        // Cash taken in the final window cycle still counts as collected.
        if (bus.money_taken) begin
          nextState  = ST_DONE;
          statusNext = STAT_OK;
          statusWr   = 1'b1;
        end else if (timerExpired) begin
          nextState = ST_RETRACT;
        end
      end
      ST_RETRACT: begin
        nextState  = ST_DONE;
        statusNext = STAT_RETRACTED;
        statusWr   = 1'b1;
      end
      ST_DONE: begin
        nextState = ST_IDLE;
      end
      default: begin
        nextState = ST_IDLE;
      end
    endcase
  end

  // Amount, note counters, inventory, jam flag and reported status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remAmt    <= '0;
      needCnt   <= '0;
      notesCnt  <= '0;
      invCnt    <= '0;
      jamFlag   <= 1'b0;
      statusReg <= STAT_OK;
    end else begin
      if (loadAccept) begin
        invCnt  <= invSum[INV_W] ? {INV_W{1'b1}} : invSum[INV_W-1:0];
        jamFlag <= 1'b0;
      end
      if (acceptReq) begin
        remAmt   <= bus.amount;
        needCnt  <= '0;
        notesCnt <= '0;
      end
      if (calcStep) begin
        remAmt  <= remAmt - AMT_W'(NOTE_VALUE);
        needCnt <= needCnt + INV_W'(1);
      end
      // CHECK has already guaranteed need <= inventory, so this cannot wrap.
      if (noteEvt) begin
        invCnt   <= invCnt - INV_W'(1);
        notesCnt <= notesCnt + INV_W'(1);
      end
      if (setJam) begin
        jamFlag <= 1'b1;
      end
      if (statusWr) begin
        statusReg <= statusNext;
      end
    end
  end

`ifdef JAM_RETRY_EN
  // One retry per note: armed by the first timeout, cleared by a sensed note or a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retryFlag <= 1'b0;
    end else if (acceptReq || noteEvt) begin
      retryFlag <= 1'b0;
    end else if (retrySet) begin
      retryFlag <= 1'b1;
    end
  end
`endif

  assign bus.note_feed    = (curState == ST_FEED);
  assign bus.shutter_open = (curState == ST_PRESENT);
  assign bus.retract      = (curState == ST_RETRACT);
  assign bus.busy         = (curState != ST_IDLE);
  assign bus.done         = (curState == ST_DONE);
  assign bus.status       = statusReg;
  assign bus.jammed       = jamFlag;
  assign bus.inventory    = invCnt;
  assign bus.notes_out    = notesCnt;
  assign bus.state        = curState;
endmodule

// File: tb/tb_atm_cash_dispense_ctrl.sv
// Self-checking bench for the ATM cash dispense controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_atm_cash_dispense_ctrl;
  localparam int NV   = 20;
  localparam int MAXN = 40;
  localparam int FT   = 8;
  localparam int PT   = 64;
  localparam int INVMAX = 4095;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  atm_cash_dispense_ctrl_if #(.AMT_W(16), .INV_W(12)) bus();

  atm_cash_dispense_ctrl #(
    .NOTE_VALUE(NV), .AMT_W(16), .INV_W(12), .MAX_NOTES(MAXN),
    .FEED_TIMEOUT(FT), .PRESENT_TIMEOUT(PT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int mInv   = 0;
  bit mJam   = 1'b0;
`ifdef JAM_RETRY_EN
  bit retryEn = 1'b1;
`else
  bit retryEn = 1'b0;
`endif

  // Reference: what a transaction should produce, from the arithmetic rules.
  task automatic model_txn(input int amt, input int dropIdx, input int dropTimes, input bit take,
                           output int eStatus, output int eFeeds, output int eNotes);
    int need;
    int retries;
    retries = retryEn ? 1 : 0;
    eFeeds = 0;
    eNotes = 0;
    if (mJam) eStatus = 3;
    else if (amt == 0 || (amt % NV) != 0 || (amt / NV) > MAXN) eStatus = 1;
    else begin
      need = amt / NV;
      if (need > mInv) eStatus = 2;
      else if (dropIdx >= 0 && dropIdx < need && dropTimes > retries) begin
        eStatus = 3;
        eNotes  = dropIdx;
        eFeeds  = dropIdx + retries + 1;
        mInv    = mInv - dropIdx;
        mJam    = 1'b1;
      end else begin
        eFeeds  = need + ((dropIdx >= 0 && dropIdx < need) ? dropTimes : 0);
        eNotes  = need;
        mInv    = mInv - need;
        eStatus = take ? 0 : 4;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.dispense_req = 0; bus.amount = 0; bus.load_notes = 0; bus.load_count = 0;
    bus.note_sensed = 0; bus.money_taken = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mInv = 0;
    mJam = 1'b0;
  endtask

  task automatic do_load(input int n);
    @(negedge clk);
    bus.load_notes = 1'b1;
    bus.load_count = n[11:0];
    @(negedge clk);
    bus.load_notes = 1'b0;
    mInv = (mInv + n > INVMAX) ? INVMAX : mInv + n;
    mJam = 1'b0;
  endtask

  // Issues one request and plays the mechanism and customer until done.
  task automatic run_txn(input int amt, input int dropIdx, input int dropTimes, input bit take,
                         output int feeds, output int shutCyc, output int retr,
                         output int doneAt, output int lastFeedAt, output logic [2:0] st);
    int sensed;
    int ignored;
    int cnt;
    int i;
    sensed = 0; ignored = 0; cnt = 0; i = 1;
    feeds = 0; shutCyc = 0; retr = 0; doneAt = -1; lastFeedAt = -1; st = 3'bxxx;
    @(negedge clk);
    bus.dispense_req = 1'b1;
    bus.amount = amt[15:0];
    @(negedge clk);
    bus.dispense_req = 1'b0;
    while (doneAt < 0 && i <= 600) begin
      bus.note_sensed = 1'b0;
      bus.money_taken = 1'b0;
      if (bus.done) begin
        doneAt = i;
        st = bus.status;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.note_sensed = 1'b1;
            sensed++;
          end
        end
        if (bus.note_feed) begin
          feeds++;
          lastFeedAt = i;
          if (sensed == dropIdx && ignored < dropTimes) ignored++;
          else cnt = 2;
        end
        if (bus.shutter_open) begin
          shutCyc++;
          if (take && shutCyc == 3) bus.money_taken = 1'b1;
        end
        if (bus.retract) retr++;
        @(negedge clk);
        i++;
      end
    end
    bus.note_sensed = 1'b0;
    bus.money_taken = 1'b0;
    checks++;
    if (doneAt < 0) begin
      errors++;
      $display("FAIL txn_timeout: amount %0d got no done within 600 cycles", amt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.state !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.note_feed !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d busy=%b done=%b feed=%b expected 0", bus.state, bus.busy, bus.done, bus.note_feed);
    end
    checks++;
    if (bus.inventory !== 12'd0 || bus.notes_out !== 12'd0 || bus.status !== 3'd0 || bus.jammed !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: inv=%0d notes=%0d status=%0d jammed=%b expected 0", bus.inventory, bus.notes_out, bus.status, bus.jammed);
    end
  endtask

  task automatic test_normal();
    int f, s, r, d, lf, es, ef, en;
    logic [2:0] st;
    do_load(100);
    checks++;
    if (bus.inventory !== 12'(mInv)) begin errors++; $display("FAIL load_100: inv=%0d expected %0d", bus.inventory, mInv); end
    model_txn(60, -1, 0, 1'b1, es, ef, en);
    run_txn(60, -1, 0, 1'b1, f, s, r, d, lf, st);
    checks++;
    if (st !== 3'(es) || f != ef || s == 0 || r != 0) begin
      errors++;
      $display("FAIL normal_60: status=%0d feeds=%0d shutter=%0d retract=%0d expected status %0d feeds %0d shutter>0", st, f, s, r, es, ef);
    end
    checks++;
    if (bus.inventory !== 12'd97 || bus.notes_out !== 12'd3) begin
      errors++; $display("FAIL normal_counts: inv=%0d notes=%0d expected 97 3", bus.inventory, bus.notes_out);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.status !== 3'd0) begin
      errors++; $display("FAIL done_pulse: done=%b busy=%b status=%0d expected 0 0 0", bus.done, bus.busy, bus.status);
    end
    // Largest legal withdrawal: exactly MAX_NOTES notes.
    model_txn(MAXN * NV, -1, 0, 1'b1, es, ef, en);
    run_txn(MAXN * NV, -1, 0, 1'b1, f, s, r, d, lf, st);
    checks++;
    if (st !== 3'(es) || f != ef || bus.inventory !== 12'(mInv) || bus.notes_out !== 12'(en)) begin
      errors++;
      $display("FAIL max_notes: status=%0d feeds=%0d inv=%0d notes=%0d expected %0d %0d %0d %0d", st, f, bus.inventory, bus.notes_out, es, ef, mInv, en);
    end
  endtask

  task automatic test_bad_amount();
    int amts[3] = '{50, 0, (MAXN + 1) * NV};
    int f, s, r, d, lf, es, ef, en;
    logic [2:0] st;
    for (int k = 0; k < 3; k++) begin
      model_txn(amts[k], -1, 0, 1'b1, es, ef, en);
      run_txn(amts[k], -1, 0, 1'b1, f, s, r, d, lf, st);
      checks++;
      if (st !== 3'd1 || f != 0 || st !== 3'(es)) begin
        errors++; $display("FAIL bad_amount_%0d: status=%0d feeds=%0d expected 1 0", amts[k], st, f);
      end
    end
    run_txn(50, -1, 0, 1'b1, f, s, r, d, lf, st);
    checks++;
    if (d < 1 || d > 4) begin errors++; $display("FAIL bad_latency: done after %0d cycles expected <= 4", d); end
  endtask

  task automatic test_no_cash();
    int f, s, r, d, lf, es, ef, en;
    logic [2:0] st;
    do_reset();
    do_load(2);
    model_txn(60, -1, 0, 1'b1, es, ef, en);
    run_txn(60, -1, 0, 1'b1, f, s, r, d, lf, st);
    checks++;
    if (st !== 3'd2 || f != 0 || bus.inventory !== 12'd2 || st !== 3'(es)) begin
      errors++; $display("FAIL no_cash: status=%0d feeds=%0d inv=%0d expected 2 0 2", st, f, bus.inventory);
    end
  endtask

  task automatic test_jam();
    int f, s, r, d, lf, es, ef, en;
    logic [2:0] st;
    do_reset();
    do_load(100);
    model_txn(40, 1, 100, 1'b1, es, ef, en);
    run_txn(40, 1, 100, 1'b1, f, s, r, d, lf, st);
    checks++;
    if (st !== 3'd3 || f != ef || bus.jammed !== 1'b1 || bus.inventory !== 12'd99) begin
      errors++; $display("FAIL jam: status=%0d feeds=%0d jammed=%b inv=%0d expected 3 %0d 1 99", st, f, bus.jammed, bus.inventory, ef);
    end
    // Last wait cycle is FT cycles after the final feed; done follows it.
    checks++;
    if (d - lf != FT + 1) begin errors++; $display("FAIL jam_timing: done %0d cycles after feed expected %0d", d - lf, FT + 1); end
    model_txn(20, -1, 0, 1'b1, es, ef, en);
    run_txn(20, -1, 0, 1'b1, f, s, r, d, lf, st);
    checks++;
    if (st !== 3'd3 || f != 0 || st !== 3'(es)) begin
      errors++; $display("FAIL jam_sticky: status=%0d feeds=%0d expected 3 0", st, f);
    end
    do_load(5);
    checks++;
    if (bus.jammed !== 1'b0 || bus.inventory !== 12'(mInv)) begin
      errors++; $display("FAIL jam_clear: jammed=%b inv=%0d expected 0 %0d", bus.jammed, bus.inventory, mInv);
    end
  endtask

  task automatic test_retract();
    int f, s, r, d, lf, es, ef, en;
    logic [2:0] st;
    model_txn(20, -1, 0, 1'b0, es, ef, en);
    run_txn(20, -1, 0, 1'b0, f, s, r, d, lf, st);
    checks++;
    if (st !== 3'd4 || s != PT || r != 1 || st !== 3'(es)) begin
      errors++; $display("FAIL retract: status=%0d shutter=%0d retracts=%0d expected 4 %0d 1", st, s, r, PT);
    end
    checks++;
    if (bus.inventory !== 12'(mInv)) begin errors++; $display("FAIL retract_inv: inv=%0d expected %0d", bus.inventory, mInv); end
  endtask

  task automatic test_single_miss();
    int f, s, r, d, lf, es, ef, en;
    logic [2:0] st;
    do_reset();
    do_load(10);
    model_txn(20, 0, 1, 1'b1, es, ef, en);
    run_txn(20, 0, 1, 1'b1, f, s, r, d, lf, st);
    checks++;
    if (st !== 3'(es) || f != ef || bus.inventory !== 12'(mInv) || bus.jammed !== mJam) begin
      errors++;
      $display("FAIL single_miss: status=%0d feeds=%0d inv=%0d jammed=%b expected %0d %0d %0d %b", st, f, bus.inventory, bus.jammed, es, ef, mInv, mJam);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    do_load(4000);
    do_load(4000);
    checks++;
    if (bus.inventory !== 12'(INVMAX) || mInv != INVMAX) begin
      errors++; $display("FAIL load_saturate: inv=%0d expected %0d", bus.inventory, INVMAX);
    end
  endtask

  task automatic test_reset_mid();
    int i;
    do_reset();
    do_load(10);
    @(negedge clk);
    bus.dispense_req = 1'b1;
    bus.amount = 16'd40;
    @(negedge clk);
    bus.dispense_req = 1'b0;
    i = 0;
    while (bus.state !== 4'd4 && i < 20) begin @(negedge clk); i++; end
    checks++;
    if (bus.state !== 4'd4) begin errors++; $display("FAIL reach_wait: state=%0d expected 4", bus.state); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.busy !== 1'b0 || bus.note_feed !== 1'b0 || bus.shutter_open !== 1'b0 ||
        bus.retract !== 1'b0 || bus.done !== 1'b0 || bus.status !== 3'd0 || bus.jammed !== 1'b0 ||
        bus.inventory !== 12'd0 || bus.notes_out !== 12'd0) begin
      errors++;
      $display("FAIL async_reset: state=%0d busy=%b inv=%0d notes=%0d expected all 0", bus.state, bus.busy, bus.inventory, bus.notes_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mInv = 0;
    mJam = 1'b0;
  endtask

  task automatic test_random();
    int f, s, r, d, lf, es, ef, en;
    int kind, amt, dropIdx, dropTimes;
    bit take;
    logic [2:0] st;
    for (int n = 0; n < 14; n++) begin
      if (mInv < 10 || mJam) do_load(50);
      kind = $urandom_range(0, 5);
      dropIdx = -1;
      dropTimes = 0;
      take = ($urandom_range(0, 3) != 0);
      case (kind)
        3: amt = $urandom_range(1, 300);
        4: begin amt = NV * $urandom_range(1, 4); dropIdx = $urandom_range(0, amt / NV - 1); dropTimes = 100; end
        5: begin do_load($urandom_range(0, 50)); amt = NV * $urandom_range(1, 5); end
        default: amt = NV * $urandom_range(1, 5);
      endcase
      model_txn(amt, dropIdx, dropTimes, take, es, ef, en);
      run_txn(amt, dropIdx, dropTimes, take, f, s, r, d, lf, st);
      checks++;
      if (st !== 3'(es) || f != ef) begin
        errors++; $display("FAIL rand_%0d_result: amt=%0d status=%0d feeds=%0d expected %0d %0d", n, amt, st, f, es, ef);
      end
      checks++;
      if (bus.inventory !== 12'(mInv) || bus.notes_out !== 12'(en) || bus.jammed !== mJam) begin
        errors++;
        $display("FAIL rand_%0d_state: inv=%0d notes=%0d jammed=%b expected %0d %0d %b", n, bus.inventory, bus.notes_out, bus.jammed, mInv, en, mJam);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_amount();
    test_retract();
    test_no_cash();
    test_jam();
    test_single_miss();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
